// File: rtl/serial_pkg.sv
// serial_pkg: shared types and constants for the serial_rx receiver.
package serial_pkg;

    localparam int DATA_BITS            = 8;
    localparam int CLKS_PER_BIT_DEFAULT = 104;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // 2-of-3 vote used when majority sampling is built in.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for an asynchronous level; both flops reset
// to 1 so an idle-high line looks idle straight out of reset.
module sync2 (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_sync;

    // Two back-to-back flops; r_meta may go metastable, r_sync is clean.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/serial_rx.sv
// serial_rx: 8N1 UART receiver, LSB first, mid-bit sampling.
// Build option SERIAL_RX_MAJORITY_EN: each bit decision is the 2-of-3 vote
// of rxs around the nominal sample cycle instead of a single sample.
//
// state | meaning
// IDLE  | waiting for a high-to-low edge on rxs
// START | half-bit wait, then confirm the start bit is still low
// DATA  | eight samples one bit period apart, shifted in LSB first
// STOP  | one bit period after data bit 7, check the stop bit
module serial_rx
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] out,
    output logic       stop,
    output logic       busy,
    output logic       ferr
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    rx_state_t            r_state;
    rx_state_t            w_next;
    logic                 w_rxs;
    logic                 r_prev;
    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic [7:0]           r_out;
    logic                 r_stop;
    logic                 r_ferr;
    logic                 w_tick;
    logic                 w_bit;
    logic                 w_fall;
    logic                 w_busy;
    logic                 w_shift_en;
    logic                 w_done_ok;
    logic                 w_done_err;

    sync2 u_sync (
        .i_clk (clk),
        .i_rst (reset),
        .i_d   (rx),
        .o_q   (w_rxs)
    );

    // The nominal sample is r_prev (one cycle before the decision edge), so
    // the majority window can include the following cycle (w_rxs) without
    // moving any decision edge.
`ifdef SERIAL_RX_MAJORITY_EN
    logic r_prev2;

    // rxs history: previous and second-previous values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev  <= 1'b1;
            r_prev2 <= 1'b1;
        end else begin
            r_prev  <= w_rxs;
            r_prev2 <= r_prev;
        end
    end

    assign w_bit = maj3(r_prev2, r_prev, w_rxs);
`else
    // rxs history: previous value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_prev <= 1'b1;
        else       r_prev <= w_rxs;
    end

    assign w_bit = r_prev;
`endif

    assign w_fall = r_prev & ~w_rxs;
    assign w_tick = (r_cnt == '0);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_fall) w_next = START;
            START:   if (w_tick) w_next = w_bit ? IDLE : DATA;
            DATA:    if (w_tick && (r_idx == IDX_LAST)) w_next = STOP;
            STOP:    if (w_tick) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Output / datapath-control decode.
    always_comb begin
        w_busy     = (r_state != IDLE);
        w_shift_en = (r_state == DATA) && w_tick;
        w_done_ok  = (r_state == STOP) && w_tick && w_bit;
        w_done_err = (r_state == STOP) && w_tick && !w_bit;
    end

    // Bit timer: parked at half a bit in IDLE, reloaded to a full bit on every
    // tick, so it never wraps. START therefore lasts CLKS_PER_BIT/2 + 1 cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                r_cnt <= '0;
        else if (r_state == IDLE) r_cnt <= CNT_HALF;
        else if (w_tick)          r_cnt <= CNT_BIT;
        else                      r_cnt <= r_cnt - CNT_W'(1);
    end

    // Data bit index and LSB-first shift register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            if (r_state != DATA) r_idx <= '0;
            else if (w_tick)     r_idx <= r_idx + IDX_W'(1);
            if (w_shift_en) r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
        end
    end

    // Result registers: out updates only together with the stop pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out  <= '0;
            r_stop <= 1'b0;
            r_ferr <= 1'b0;
        end else begin
            r_stop <= w_done_ok;
            r_ferr <= w_done_err;
            if (w_done_ok) r_out <= r_shift;
        end
    end

    assign out  = r_out;
    assign stop = r_stop;
    assign ferr = r_ferr;
    assign busy = w_busy;

endmodule

// File: tb/tb_serial_rx.sv
// tb_serial_rx: directed + random frames against a frame-level model.
module tb_serial_rx;
    localparam int C   = 16;
    localparam int LAT = 2 + C/2 + 9*C + 1;

    typedef struct {
        int         t;
        logic       ok;
        logic [7:0] b;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic [7:0] out;
    logic       stop;
    logic       busy;
    logic       ferr;

    int         n_assert = 0;
    int         n_fail   = 0;
    int         ncyc     = 0;
    int         busy_run = 0;
    int         busy_max = 0;
    ev_t        exp_q[$];
    logic [7:0] exp_out  = 8'h00;
    logic [7:0] prev_out = 8'h00;

    serial_rx #(.CLKS_PER_BIT(C)) dut (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .out   (out),
        .stop  (stop),
        .busy  (busy),
        .ferr  (ferr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    // Per-cycle observation: match stop/ferr pulses against expected frame events.
    task automatic monitor();
        ev_t ev;
        if (reset) begin
            busy_run = 0;
            prev_out = out;
            return;
        end
        if (busy) busy_run++; else busy_run = 0;
        if (busy_run > busy_max) busy_max = busy_run;
        while (exp_q.size() > 0 && ncyc > exp_q[0].t) begin
            chk("event_missed_time", ncyc, exp_q[0].t);
            void'(exp_q.pop_front());
        end
        if (out !== prev_out) chk("out_changed_with_stop", stop, 1);
        prev_out = out;
        if (stop || ferr) begin
            chk("stop_ferr_exclusive", stop & ferr, 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_event", {stop, ferr}, 0);
            end else begin
                ev = exp_q.pop_front();
                chk("event_time", ncyc, ev.t);
                chk("event_stop", stop, ev.ok);
                chk("event_ferr", ferr, !ev.ok);
                if (ev.ok) exp_out = ev.b;
                chk("event_out", out, exp_out);
            end
        end
    endtask

    // One clock: drive rx just after the rising edge, observe at the falling edge.
    task automatic cyc(input logic v);
        @(posedge clk);
        #1 rx = v;
        @(negedge clk);
        ncyc++;
        monitor();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1);
    endtask

    // Send one frame; inv flips the line for one cycle at the middle of each
    // selected data bit. The model: single sampling takes the flipped value,
    // majority voting rejects it.
    task automatic send_frame(input logic [7:0] d, input logic sb, input logic [7:0] inv);
        ev_t ev;
        logic [7:0] rcv;
`ifdef SERIAL_RX_MAJORITY_EN
        rcv = d;
`else
        rcv = d ^ inv;
`endif
        ev.t  = ncyc + LAT + 2;
        ev.ok = sb;
        ev.b  = rcv;
        exp_q.push_back(ev);
        for (int i = 0; i < 10*C; i++) begin
            int   b;
            logic v;
            b = i / C;
            if (b == 0)      v = 1'b0;
            else if (b == 9) v = sb;
            else             v = d[b-1];
            if (b >= 1 && b <= 8 && inv[b-1] && i == b*C + C/2) v = ~v;
            cyc(v);
            if (i == 5*C) chk("busy_mid_frame", busy, 1);
        end
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] inv;
        logic [7:0] f7e;
        logic       sb;
        logic       prev_err;
        int         base;
        ev_t        gev;

        // Reset state
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out", out, 0);
        chk("reset_stop", stop, 0);
        chk("reset_ferr", ferr, 0);
        chk("reset_busy", busy, 0);
        reset = 1'b0;
        idle(5);

        // Single frame 'A'
        send_frame(8'h41, 1'b1, 8'h00);
        idle(2*C);
        chk("out_after_41", out, 8'h41);

        // Back-to-back frames
        send_frame(8'h31, 1'b1, 8'h00);
        send_frame(8'h0D, 1'b1, 8'h00);
        idle(2*C);
        chk("out_after_0d", out, 8'h0D);

        // Framing error, line held low, then recovery
        send_frame(8'h55, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) cyc(1'b0);
        idle(2*C);
        chk("out_kept_after_ferr", out, 8'h0D);
        send_frame(8'h30, 1'b1, 8'h00);
        idle(2*C);
        chk("out_after_30", out, 8'h30);

        // Four-cycle low glitch on idle line
        busy_max = 0;
        for (int i = 0; i < 4; i++) cyc(1'b0);
        idle(2*C);
        chk("glitch_busy_seen", busy_max > 0, 1);
        chk("glitch_busy_le_10", busy_max <= 10, 1);
        chk("glitch_back_idle", busy, 0);

        // Reset during data bit 3 of 0x7E; bit 7 (low) later forms a genuine
        // edge, so the tail is received as a frame of all ones.
        f7e  = 8'h7E;
        base = ncyc;
        gev.t  = base + 8*C + LAT + 2;
        gev.ok = 1'b1;
        gev.b  = 8'hFF;
        exp_q.push_back(gev);
        for (int i = 0; i < 10*C; i++) begin
            int   b;
            logic v;
            b = i / C;
            if (b == 0)      v = 1'b0;
            else if (b == 9) v = 1'b1;
            else             v = f7e[b-1];
            cyc(v);
            if (i == 4*C + 4) begin
                #2 reset = 1'b1;
                #1;
                chk("midreset_out", out, 0);
                chk("midreset_stop", stop, 0);
                chk("midreset_ferr", ferr, 0);
                chk("midreset_busy", busy, 0);
                exp_out = 8'h00;
            end
            if (i == 4*C + 8) reset = 1'b0;
        end
        idle(12*C);
        send_frame(8'h24, 1'b1, 8'h00);
        idle(2*C);
        chk("out_after_24", out, 8'h24);

        // One-cycle inversion at the middle of every data bit of 0xA5
        send_frame(8'hA5, 1'b1, 8'hFF);
        idle(2*C);
`ifdef SERIAL_RX_MAJORITY_EN
        chk("out_after_a5_glitched", out, 8'hA5);
`else
        chk("out_after_a5_glitched", out, 8'h5A);
`endif

        // Random frames, gaps, stop bits and glitches
        prev_err = 1'b0;
        for (int n = 0; n < 8; n++) begin
            d   = 8'($urandom_range(0, 255));
            sb  = ($urandom_range(0, 3) != 0);
            inv = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 255)) : 8'h00;
            idle(prev_err ? int'($urandom_range(2, 6)) : int'($urandom_range(0, 4)));
            send_frame(d, sb, inv);
            prev_err = !sb;
        end
        idle(2*C);

        chk("no_pending_events", exp_q.size(), 0);
        chk("final_out", out, exp_out);
        chk("final_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
